// File: rtl/apb_uart_regs.sv
`default_nettype none
// ============================================================================
// Module      : apb_uart_regs
// Description : APB3 register front end of the APB UART. Bus writes to DATA
//               push the TX FIFO, bus reads of DATA pop the RX FIFO (one wait
//               state). Also holds the baud divisor, sticky error flags and an
//               optional interrupt controller.
// Optional    : define UART_IRQ_EN to build IER/ISR/irq; otherwise IER and ISR
//               read as 0 (no error) and irq is tied low.
// Ports       : clk, rst_n (async, active low)
//               paddr/psel/penable/pwrite/pwdata -> prdata/pready/pslverr (APB3)
//               tx_fifo_wr_en/tx_fifo_din, tx_fifo_full/tx_fifo_empty (TX FIFO)
//               rx_fifo_rd_en, rx_fifo_dout/full/empty (RX FIFO)
//               rx_ready, rx_error (uart_rx pulses)
//               divisor (baud generator), irq (level interrupt)
// Revision    : 1.0 - initial release
// ============================================================================
module apb_uart_regs #(
  parameter int          DATA_WIDTH = 8,
  parameter logic [31:0] DIV_RESET  = 32'd16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4:0]            paddr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic                  tx_fifo_wr_en,
  output logic [DATA_WIDTH-1:0] tx_fifo_din,
  input  logic                  tx_fifo_full,
  input  logic                  tx_fifo_empty,
  output logic                  rx_fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] rx_fifo_dout,
  input  logic                  rx_fifo_full,
  input  logic                  rx_fifo_empty,
  input  logic                  rx_ready,
  input  logic                  rx_error,
  output logic [31:0]           divisor,
  output logic                  irq
);

  localparam logic [2:0] c_ADDR_DATA   = 3'd0;
  localparam logic [2:0] c_ADDR_STATUS = 3'd1;
  localparam logic [2:0] c_ADDR_DIV    = 3'd2;
  localparam logic [2:0] c_ADDR_IER    = 3'd3;
  localparam logic [2:0] c_ADDR_ISR    = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_POP  = 2'd1,
    RD_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        rd_empty_q, rd_empty_d;   // RX FIFO was empty when the read was decoded
  logic [31:0] divisor_q, divisor_d;
  logic [2:0]  sticky_q, sticky_d;       // {RX_OVF, TX_OVF, RX_ERR}

  logic [2:0]  w_addr;
  logic        w_access;
  logic        w_reg_wr;
  logic        w_wr_en, w_rd_en;
  logic        w_pready, w_pslverr;
  logic [31:0] w_prdata, w_reg_rdata, w_status;
  logic [3:0]  w_ier, w_isr;
  logic [2:0]  w_sticky_set, w_sticky_clr;
  logic        w_unused;

  assign w_addr   = paddr[4:2];
  assign w_access = psel & penable;
  assign w_unused = ^paddr[1:0];

  assign w_status = {25'd0, sticky_q[2], sticky_q[1], sticky_q[0],
                     rx_fifo_empty, rx_fifo_full, tx_fifo_empty, tx_fifo_full};

  always_comb begin
    w_reg_rdata = 32'd0;
    case (w_addr)
      c_ADDR_STATUS: w_reg_rdata = w_status;
      c_ADDR_DIV:    w_reg_rdata = divisor_q;
      c_ADDR_IER:    w_reg_rdata = {28'd0, w_ier};
      c_ADDR_ISR:    w_reg_rdata = {28'd0, w_isr};
      default:       w_reg_rdata = 32'd0;
    endcase
  end

  // Access FSM. The pop is issued in the decode cycle so the FIFO output is
  // valid in the following cycle, which completes the transfer. RD_DONE is a
  // guard cycle: even if the master keeps psel/penable high, no second pop.
  always_comb begin
    state_d    = state_q;
    rd_empty_d = rd_empty_q;
    w_pready   = 1'b0;
    w_pslverr  = 1'b0;
    w_prdata   = 32'd0;
    w_wr_en    = 1'b0;
    w_rd_en    = 1'b0;
    w_reg_wr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_access) begin
          if (!pwrite && w_addr == c_ADDR_DATA) begin
            state_d    = RD_POP;
            w_rd_en    = ~rx_fifo_empty;
            rd_empty_d = rx_fifo_empty;
          end else begin
            w_pready  = 1'b1;
            w_reg_wr  = pwrite;
            w_prdata  = pwrite ? 32'd0 : w_reg_rdata;
            w_wr_en   = pwrite && (w_addr == c_ADDR_DATA) && !tx_fifo_full;
            w_pslverr = (w_addr > c_ADDR_ISR) ||
                        (pwrite && (w_addr == c_ADDR_DATA) && tx_fifo_full);
          end
        end
      end
      RD_POP: begin
        w_pready  = 1'b1;
        w_pslverr = rd_empty_q;
        w_prdata  = rd_empty_q ? 32'd0 : 32'(rx_fifo_dout);
        state_d   = RD_DONE;
      end
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Set beats clear when both hit the same flag in one cycle.
  assign w_sticky_set = {rx_ready & rx_fifo_full,
                         w_reg_wr & (w_addr == c_ADDR_DATA) & tx_fifo_full,
                         rx_error};
  assign w_sticky_clr = (w_reg_wr && w_addr == c_ADDR_STATUS) ? pwdata[6:4] : 3'd0;

  always_comb begin
    sticky_d  = (sticky_q & ~w_sticky_clr) | w_sticky_set;
    divisor_d = divisor_q;
    if (w_reg_wr && w_addr == c_ADDR_DIV) divisor_d = pwdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_empty_q <= 1'b0;
      divisor_q  <= DIV_RESET;
      sticky_q   <= 3'd0;
    end else begin
      state_q    <= state_d;
      rd_empty_q <= rd_empty_d;
      divisor_q  <= divisor_d;
      sticky_q   <= sticky_d;
    end
  end

`ifdef UART_IRQ_EN
  logic [3:0] ier_q, ier_d;
  logic       irq_q, irq_d;
  logic [3:0] w_pending;

  always_comb begin
    // {rx full, any sticky error, tx empty, rx data available}
    w_pending = {rx_fifo_full, |sticky_q, tx_fifo_empty, ~rx_fifo_empty};
    ier_d     = ier_q;
    if (w_reg_wr && w_addr == c_ADDR_IER) ier_d = pwdata[3:0];
    w_ier     = ier_q;
    w_isr     = w_pending & ier_q;
    irq_d     = |w_isr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ier_q <= 4'd0;
      irq_q <= 1'b0;
    end else begin
      ier_q <= ier_d;
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign w_ier = 4'd0;
  assign w_isr = 4'd0;
  assign irq   = 1'b0;
`endif

  assign prdata        = w_prdata;
  assign pready        = w_pready;
  assign pslverr       = w_pslverr;
  assign divisor       = divisor_q;
  assign tx_fifo_din   = pwdata[DATA_WIDTH-1:0];
  // Strobes drop with reset asynchronously, independent of the inputs.
  assign tx_fifo_wr_en = w_wr_en & rst_n;
  assign rx_fifo_rd_en = w_rd_en & rst_n;

endmodule
`default_nettype wire

// File: tb/tb_apb_uart_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_uart_regs
// Description : Directed self-checking bench for apb_uart_regs. Expected
//               values are hand-computed; a one-entry RX FIFO model returns
//               its byte only in the cycle after a pop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_uart_regs;

`ifdef UART_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic        tx_fifo_wr_en;
  logic [7:0]  tx_fifo_din;
  logic        tx_fifo_full, tx_fifo_empty;
  logic        rx_fifo_rd_en;
  logic [7:0]  rx_fifo_dout;
  logic        rx_fifo_full, rx_fifo_empty;
  logic        rx_ready, rx_error;
  logic [31:0] divisor;
  logic        irq;

  always #5 clk = ~clk;

  apb_uart_regs #(.DATA_WIDTH(8), .DIV_RESET(32'd16)) dut (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .tx_fifo_wr_en(tx_fifo_wr_en), .tx_fifo_din(tx_fifo_din),
    .tx_fifo_full(tx_fifo_full), .tx_fifo_empty(tx_fifo_empty),
    .rx_fifo_rd_en(rx_fifo_rd_en), .rx_fifo_dout(rx_fifo_dout),
    .rx_fifo_full(rx_fifo_full), .rx_fifo_empty(rx_fifo_empty),
    .rx_ready(rx_ready), .rx_error(rx_error), .divisor(divisor), .irq(irq)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] rx_byte;
  logic       pop_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // RX FIFO model: the popped byte appears on dout the cycle after rd_en.
  task automatic apply_pop();
    if (pop_pend) begin
      rx_fifo_dout  = rx_byte;
      rx_fifo_empty = 1'b1;
      pop_pend      = 1'b0;
    end
  endtask

  task automatic apb_read(input logic [4:0] a, output logic [31:0] data,
                          output logic err, output int waits, output int pops);
    logic done;
    done = 1'b0; waits = 0; pops = 0; data = '0; err = 1'b0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge clk);
    if (rx_fifo_rd_en) begin pops++; pop_pend = 1'b1; end
    @(posedge clk); #1;
    apply_pop();
    penable = 1'b1;
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge clk);
      if (rx_fifo_rd_en) begin pops++; pop_pend = 1'b1; end
      if (pready) begin done = 1'b1; data = prdata; err = pslverr; end
      else waits++;
      @(posedge clk); #1;
      apply_pop();
    end
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    if (rx_fifo_rd_en) pops++;
    if (!done) check("read_timeout", 32'(done), 32'd1);
  endtask

  task automatic apb_write(input logic [4:0] a, input logic [31:0] d, input logic perr,
                           output logic err, output int wrs, output logic [7:0] din,
                           output int waits);
    logic done;
    done = 1'b0; wrs = 0; din = '0; err = 1'b0; waits = 0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge clk);
    if (tx_fifo_wr_en) wrs++;
    @(posedge clk); #1;
    penable = 1'b1; rx_error = perr;
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge clk);
      if (tx_fifo_wr_en) begin wrs++; din = tx_fifo_din; end
      if (pready) begin done = 1'b1; err = pslverr; end
      else waits++;
      @(posedge clk); #1;
    end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; rx_error = 1'b0;
    if (!done) check("write_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          w, p, wr;
    logic [7:0]  din;

    rst_n = 1'b0; paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwdata = '0;
    tx_fifo_full = 1'b0; tx_fifo_empty = 1'b1; rx_fifo_full = 1'b0; rx_fifo_empty = 1'b1;
    rx_fifo_dout = 8'hEE; rx_ready = 1'b0; rx_error = 1'b0; rx_byte = 8'h00; pop_pend = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_prdata", prdata, 32'h0);
    check("rst_pready", 32'(pready), 32'h0);
    check("rst_pslverr", 32'(pslverr), 32'h0);
    check("rst_wr_en", 32'(tx_fifo_wr_en), 32'h0);
    check("rst_rd_en", 32'(rx_fifo_rd_en), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_divisor", divisor, 32'h10);
    rst_n = 1'b1;

    // DIVISOR
    apb_read(5'h08, rd, err, w, p);
    check("div_reset_read", rd, 32'h10);
    check("div_read_waits", 32'(w), 32'd0);
    apb_write(5'h08, 32'h20, 1'b0, err, wr, din, w);
    check("div_write_err", 32'(err), 32'd0);
    @(negedge clk);
    check("div_port", divisor, 32'h20);
    apb_read(5'h08, rd, err, w, p);
    check("div_readback", rd, 32'h20);

    // DATA write into non-full TX FIFO
    apb_write(5'h00, 32'h000000A5, 1'b0, err, wr, din, w);
    check("tx_push_count", 32'(wr), 32'd1);
    check("tx_push_din", 32'(din), 32'hA5);
    check("tx_push_err", 32'(err), 32'd0);
    check("tx_push_waits", 32'(w), 32'd0);

    // DATA write into full TX FIFO -> dropped, TX_OVF
    tx_fifo_full = 1'b1; tx_fifo_empty = 1'b0;
    apb_write(5'h00, 32'h00000011, 1'b0, err, wr, din, w);
    check("tx_full_push_count", 32'(wr), 32'd0);
    check("tx_full_err", 32'(err), 32'd1);
    tx_fifo_full = 1'b0;
    apb_read(5'h04, rd, err, w, p);
    check("status_tx_ovf", rd, 32'h28);
    apb_write(5'h04, 32'h0000000F, 1'b0, err, wr, din, w);
    apb_read(5'h04, rd, err, w, p);
    check("status_live_bits_ignore_write", rd, 32'h28);
    apb_write(5'h04, 32'h00000020, 1'b0, err, wr, din, w);
    apb_read(5'h04, rd, err, w, p);
    check("status_tx_ovf_cleared", rd, 32'h08);
    tx_fifo_empty = 1'b1;
    apb_read(5'h04, rd, err, w, p);
    check("status_idle", rd, 32'h0A);

    // DATA read with a byte available, then with the FIFO empty
    rx_byte = 8'h33; rx_fifo_empty = 1'b0;
    apb_read(5'h00, rd, err, w, p);
    check("rx_read_data", rd, 32'h33);
    check("rx_read_pops", 32'(p), 32'd1);
    check("rx_read_waits", 32'(w), 32'd1);
    check("rx_read_err", 32'(err), 32'd0);
    apb_read(5'h00, rd, err, w, p);
    check("rx_empty_data", rd, 32'h0);
    check("rx_empty_pops", 32'(p), 32'd0);
    check("rx_empty_err", 32'(err), 32'd1);
    check("rx_empty_waits", 32'(w), 32'd1);

    // Unmapped window
    apb_read(5'h18, rd, err, w, p);
    check("unmapped_read_data", rd, 32'h0);
    check("unmapped_read_err", 32'(err), 32'd1);
    apb_write(5'h14, 32'hFFFFFFFF, 1'b0, err, wr, din, w);
    check("unmapped_write_err", 32'(err), 32'd1);

    // Interrupts: RX data available
    apb_write(5'h0C, 32'h00000001, 1'b0, err, wr, din, w);
    check("ier_write_err", 32'(err), 32'd0);
    apb_read(5'h0C, rd, err, w, p);
    check("ier_readback", rd, 32'(IRQ_ON));
    @(posedge clk); #1;
    rx_byte = 8'h5A; rx_fifo_empty = 1'b0;
    @(negedge clk);
    check("irq_latency_0", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq_latency_1", 32'(irq), 32'(IRQ_ON));
    apb_read(5'h10, rd, err, w, p);
    check("isr_value", rd, 32'(IRQ_ON));
    check("isr_err", 32'(err), 32'd0);
    apb_read(5'h00, rd, err, w, p);
    check("irq_pop_data", rd, 32'h5A);
    check("irq_after_pop", 32'(irq), 32'd0);
    apb_write(5'h0C, 32'h00000000, 1'b0, err, wr, din, w);

    // Sticky set beats same-cycle clear; RX overflow
    apb_write(5'h04, 32'h00000010, 1'b1, err, wr, din, w);
    apb_read(5'h04, rd, err, w, p);
    check("rx_err_set_wins", rd, 32'h1A);
    @(posedge clk); #1;
    rx_ready = 1'b1; rx_fifo_full = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0; rx_fifo_full = 1'b0;
    apb_read(5'h04, rd, err, w, p);
    check("rx_ovf_set", rd, 32'h5A);
    apb_write(5'h04, 32'h00000070, 1'b0, err, wr, din, w);
    apb_read(5'h04, rd, err, w, p);
    check("sticky_all_cleared", rd, 32'h0A);

    // Reset asserted in the middle of a DATA read
    rx_byte = 8'h77; rx_fifo_empty = 1'b0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 5'h00;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check("rd_en_before_reset", 32'(rx_fifo_rd_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rd_en_async_reset", 32'(rx_fifo_rd_en), 32'd0);
    check("pready_async_reset", 32'(pready), 32'd0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("div_after_reset", divisor, 32'h10);

    // psel dropped after the first ACCESS cycle of a DATA read
    p = 0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 5'h00;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    if (rx_fifo_rd_en) begin p++; pop_pend = 1'b1; end
    @(posedge clk); #1;
    apply_pop();
    psel = 1'b0; penable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (rx_fifo_rd_en) p++;
    end
    check("abort_single_pop", 32'(p), 32'd1);
    apb_read(5'h08, rd, err, w, p);
    check("abort_fsm_idle_data", rd, 32'h10);
    check("abort_fsm_idle_waits", 32'(w), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
